usb_gpx_conditioner: RTL and testbench
======================================

Name: usb_gpx_conditioner

Overview:
- Front-end for the MAX3421E GPX pin, directly upstream of the GPX PIO input port.
- Synchronises the asynchronous pin and glitch-filters it; `gpx_level` drives the PIO `in_port`.
- Also has its own small Avalon-MM slave that captures rising/falling edges and raises a maskable `irq` for the Nios II USB driver.

Parameters:
- FILTER_CYCLES, 4, consecutive mismatching synchronised samples required before `gpx_level` changes; legal range 1..255.
- RESET_LEVEL, 0, reset value of the synchroniser flops and `gpx_level`.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- gpx_pin  in  1  raw GPX pin, asynchronous to clk
- address  in  2  Avalon register select
- chipselect  in  1  Avalon chipselect
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- irq  out  1  level interrupt to the CPU
- gpx_level  out  1  filtered GPX level, feeds the downstream PIO `in_port`

Behaviour:
- Clock and reset: one clock, `clk`; reset `reset_n` is asynchronous, active-low.
- Reset values:
  - sync0/sync1 = RESET_LEVEL; `gpx_level` = RESET_LEVEL; filter counter = 0.
  - ctrl = 2'b11; irqmask = 2'b00; edgecapture = 2'b00.
  - `readdata` = 0; `irq` = 0.
- Synchroniser: two flops, gpx_pin -> sync0 -> sync1. No other logic reads gpx_pin.
- Glitch filter, counter width = clog2(FILTER_CYCLES+1):
  - If sync1 == gpx_level: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: gpx_level <= sync1, cnt <= 0. This is the "update" cycle.
  - Else: cnt <= cnt+1.
  - Pin-to-`gpx_level` latency for a stable change = 2 + FILTER_CYCLES clocks.
  - A pulse shorter than FILTER_CYCLES synchronised samples produces no change.
  - With FILTER_CYCLES=1, `gpx_level` follows sync1 one clock later.
- Edge detect:
  - rise_evt = update & sync1 & ctrl[0].
  - fall_evt = update & ~sync1 & ctrl[1].
  - Evaluated in the same cycle as the update; captured on the same clk edge that updates `gpx_level`.
- Register map (word addresses). Writes require chipselect=1, write_n=0; writes to read-only addresses are ignored.
  - 0 STATUS (RO): bit0 = gpx_level, bit1 = sync1, others 0.
  - 1 CTRL (RW): bit0 rise-capture enable, bit1 fall-capture enable.
  - 2 IRQMASK (RW): bit0 rise irq enable, bit1 fall irq enable.
  - 3 EDGECAPTURE (R/W1C): bit0 rise seen, bit1 fall seen.
- Reads:
  - readdata <= mux(address) every clock, independent of chipselect; read latency 1 clock.
  - Reads have no side effects.
- EDGECAPTURE update: edgecapture[i] <= (edgecapture[i] & ~clr[i]) | evt[i].
  - An event in the same cycle as a write-1-clear leaves the bit set (set wins).
  - Writing 0 has no effect.
- irq = |(edgecapture & irqmask), combinational from registers, so it follows register state with no extra latency.
- Mask or enable changes:
  - Clearing a CTRL enable stops new captures only; already-captured bits stay.
  - Clearing an IRQMASK bit deasserts `irq` immediately; the capture bit is kept.
- Reset mid-filter: counter and level return to reset values; no edge is recorded for the reset transition.
- Post-reset: if the pin sits at ~RESET_LEVEL, one legitimate edge is recorded after 2 + FILTER_CYCLES clocks.

Decomposition:
- Shared package `usb_gpx_pkg`:
  - Register address constants: ADDR_STATUS=0, ADDR_CTRL=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - Bit-index constants: BIT_RISE=0, BIT_FALL=1.
  - The clog2 counter-width function.
- One sub-module, `gpx_sync_filter`:
  - Contains the synchroniser, glitch counter and `gpx_level` register.
  - Outputs gpx_level, sync1, rise_pulse and fall_pulse (rise/fall not yet gated by CTRL).
  - Everything else (register file, Avalon mux, irq) stays in the top.

Test Plan:
- Reset release with gpx_pin=0, FILTER_CYCLES=4 -> gpx_level=0, readdata=0, irq=0; EDGECAP reads 0 for 20 clocks.
- gpx_pin 0->1 held; IRQMASK=3 -> gpx_level=1 exactly 6 clocks after the pin change is first sampled; EDGECAP=2'b01; irq=1.
- gpx_pin high-glitch of 3 clocks (FILTER_CYCLES=4) -> gpx_level stays 0, EDGECAP stays 0, irq stays 0.
- Write 2'b01 to EDGECAP in the same cycle as a new rise_evt -> bit0 reads 1 afterwards and irq stays 1. A later W1C with no event -> bit0=0, irq=0.
- CTRL=2'b01, then gpx_pin 1->0 -> gpx_level=0 after 6 clocks; EDGECAP bit1 stays 0 (fall disabled).
- IRQMASK=0 with EDGECAP=2'b10 -> irq=0. Write IRQMASK=2'b10 -> irq=1 in the clock after the write.
- Assert reset_n mid-filter (cnt=2) -> all outputs at reset values immediately, with no irq glitch.

Source files
------------

// File: rtl/usb_gpx_pkg.sv
// Shared constants and helpers for the MAX3421E GPX pin conditioner.
package usb_gpx_pkg;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned BIT_RISE = 0;
    localparam int unsigned BIT_FALL = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < v) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/gpx_sync_filter.sv
// Two-flop synchroniser plus consecutive-sample glitch filter for GPX.
module gpx_sync_filter
    import usb_gpx_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 4,
    parameter bit          RESET_LEVEL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_sync1,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);

    localparam int unsigned CW = clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_update;

    assign w_update = (r_sync1 != r_level) && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync0 <= RESET_LEVEL;
            r_sync1 <= RESET_LEVEL;
            r_level <= RESET_LEVEL;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_pin;
            r_sync1 <= r_sync0;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (w_update) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level      = r_level;
    assign o_sync1      = r_sync1;
    assign o_rise_pulse = w_update & r_sync1;
    assign o_fall_pulse = w_update & ~r_sync1;

endmodule

// File: rtl/usb_gpx_conditioner.sv
// GPX pin conditioner: filtered level for the PIO plus an edge-capture
// Avalon-MM slave with a maskable level interrupt.
module usb_gpx_conditioner
    import usb_gpx_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 4,
    parameter bit          RESET_LEVEL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        gpx_pin,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        gpx_level
);

    logic        w_level;
    logic        w_sync1;
    logic        w_rise;
    logic        w_fall;
    logic        w_wr;
    logic [1:0]  w_evt;
    logic [1:0]  w_clr;
    logic [31:0] w_rd_mux;
    logic        w_unused_wdata;

    logic [1:0]  r_ctrl;
    logic [1:0]  r_irqmask;
    logic [1:0]  r_edgecap;
    logic [31:0] r_readdata;

    gpx_sync_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .RESET_LEVEL   (RESET_LEVEL)
    ) u_filt (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_pin        (gpx_pin),
        .o_level      (w_level),
        .o_sync1      (w_sync1),
        .o_rise_pulse (w_rise),
        .o_fall_pulse (w_fall)
    );

    assign w_unused_wdata = &{1'b0, writedata[31:2]};
    assign w_wr = chipselect & ~write_n;

    always_comb begin
        w_evt = 2'b00;
        w_evt[BIT_RISE] = w_rise & r_ctrl[BIT_RISE];
        w_evt[BIT_FALL] = w_fall & r_ctrl[BIT_FALL];
    end

    assign w_clr = (w_wr && address == ADDR_EDGECAP) ? writedata[1:0] : 2'b00;

    always_comb begin
        w_rd_mux = '0;
        unique case (address)
            ADDR_STATUS:  w_rd_mux = {30'd0, w_sync1, w_level};
            ADDR_CTRL:    w_rd_mux = {30'd0, r_ctrl};
            ADDR_IRQMASK: w_rd_mux = {30'd0, r_irqmask};
            ADDR_EDGECAP: w_rd_mux = {30'd0, r_edgecap};
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl     <= 2'b11;
            r_irqmask  <= 2'b00;
            r_edgecap  <= 2'b00;
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
            if (w_wr && address == ADDR_CTRL)
                r_ctrl <= writedata[1:0];
            if (w_wr && address == ADDR_IRQMASK)
                r_irqmask <= writedata[1:0];
            // set wins over a simultaneous write-1-clear
            r_edgecap <= (r_edgecap & ~w_clr) | w_evt;
        end
    end

    assign readdata  = r_readdata;
    assign irq       = |(r_edgecap & r_irqmask);
    assign gpx_level = w_level;

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Directed self-checking bench for usb_gpx_conditioner (FILTER_CYCLES=4).
module tb_usb_gpx_conditioner;

    logic        clk;
    logic        reset_n;
    logic        gpx_pin;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        gpx_level;

    int n_chk;
    int n_pass;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    usb_gpx_conditioner #(
        .FILTER_CYCLES (4),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .gpx_pin    (gpx_pin),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .gpx_level  (gpx_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e,
                      input string tag);
        address = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        chk(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        gpx_pin    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // reset state
        repeat (3) tick();
        chk("rst_level", 32'(gpx_level), 32'd0);
        chk("rst_rdata", readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) rd(2'd3, 32'd0, "idle_edgecap");
        rd(2'd1, 32'd3, "ctrl_reset");
        rd(2'd2, 32'd0, "irqmask_reset");

        wr(2'd2, 32'd3);
        rd(2'd2, 32'd3, "irqmask_wr");

        // 3-sample glitch must be rejected
        gpx_pin = 1'b1;
        repeat (3) tick();
        gpx_pin = 1'b0;
        repeat (10) tick();
        chk("glitch_level", 32'(gpx_level), 32'd0);
        chk("glitch_irq", 32'(irq), 32'd0);
        rd(2'd3, 32'd0, "glitch_edgecap");

        // clean rise: level changes exactly 6 clocks later
        gpx_pin = 1'b1;
        repeat (5) tick();
        chk("rise_lat5", 32'(gpx_level), 32'd0);
        tick();
        chk("rise_lat6", 32'(gpx_level), 32'd1);
        chk("rise_irq", 32'(irq), 32'd1);
        rd(2'd3, 32'd1, "rise_edgecap");
        rd(2'd0, 32'd3, "status_high");

        // fall, then clear both
        gpx_pin = 1'b0;
        repeat (8) tick();
        chk("fall_level", 32'(gpx_level), 32'd0);
        rd(2'd3, 32'd3, "fall_edgecap");
        wr(2'd3, 32'd3);
        rd(2'd3, 32'd0, "w1c_both");
        chk("w1c_irq", 32'(irq), 32'd0);

        // W1C in the same cycle as a rise event: set wins
        gpx_pin = 1'b1;
        repeat (5) tick();
        wr(2'd3, 32'd1);
        chk("coll_level", 32'(gpx_level), 32'd1);
        chk("coll_irq", 32'(irq), 32'd1);
        rd(2'd3, 32'd1, "coll_edgecap");
        wr(2'd3, 32'd0);
        rd(2'd3, 32'd1, "w0_noeffect");
        wr(2'd3, 32'd1);
        rd(2'd3, 32'd0, "w1c_rise");
        chk("w1c_rise_irq", 32'(irq), 32'd0);

        // fall capture disabled
        wr(2'd1, 32'd1);
        gpx_pin = 1'b0;
        repeat (5) tick();
        chk("fdis_lat5", 32'(gpx_level), 32'd1);
        tick();
        chk("fdis_lat6", 32'(gpx_level), 32'd0);
        rd(2'd3, 32'd0, "fdis_edgecap");
        chk("fdis_irq", 32'(irq), 32'd0);

        // masking
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd0);
        gpx_pin = 1'b1;
        repeat (8) tick();
        gpx_pin = 1'b0;
        repeat (8) tick();
        rd(2'd3, 32'd3, "mask_edgecap");
        chk("mask0_irq", 32'(irq), 32'd0);
        wr(2'd3, 32'd1);
        rd(2'd3, 32'd2, "mask_fallonly");
        chk("mask0_irq2", 32'(irq), 32'd0);
        wr(2'd2, 32'd2);
        chk("mask2_irq", 32'(irq), 32'd1);
        wr(2'd1, 32'd0);
        rd(2'd3, 32'd2, "ctrl_off_keep");
        chk("ctrl_off_irq", 32'(irq), 32'd1);

        // reset in the middle of filtering a rise
        gpx_pin = 1'b1;
        repeat (2) tick();
        rd(2'd0, 32'd2, "status_sync");
        tick();
        chk("pre_rst_irq", 32'(irq), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(gpx_level), 32'd0);
        chk("mid_rst_rdata", readdata, 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_lat5", 32'(gpx_level), 32'd0);
        tick();
        chk("post_rst_lat6", 32'(gpx_level), 32'd1);
        rd(2'd3, 32'd1, "post_rst_edge");
        chk("post_rst_irq", 32'(irq), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
